// File: rtl/cnn_frame_sched_if.sv
// Control/status bundle between the frame scheduler, the CNN layers and the UART.
// Latency: none, wires only.
// Backpressure: none; strobes are single-cycle pulses, img_rdy is a level held until img_ack.
interface cnn_frame_sched_if #(
  parameter int NUM_LAYERS = 5
);
  logic                  img_rdy;
  logic                  img_ack;
  logic [NUM_LAYERS-1:0] lyr_strt;
  logic [NUM_LAYERS-1:0] lyr_done;
  logic                  tx_trmt;
  logic                  tx_done;
  logic                  clr_err;
  logic                  busy;
  logic [2:0]            cur_layer;
  logic                  err;
  logic [2:0]            err_stage;
  logic [7:0]            frame_cnt;

  // Scheduler side
  modport master (
    input  img_rdy, lyr_done, tx_done, clr_err,
    output img_ack, lyr_strt, tx_trmt, busy, cur_layer, err, err_stage, frame_cnt
  );

  // Image source / layers / UART / debug side
  modport slave (
    output img_rdy, lyr_done, tx_done, clr_err,
    input  img_ack, lyr_strt, tx_trmt, busy, cur_layer, err, err_stage, frame_cnt
  );
endinterface

// File: rtl/cnn_frame_sched.sv
// Frame scheduler: starts each CNN layer in turn, then the UART send, with a per-stage watchdog.
// Latency: img_rdy -> lyr_strt[0] 2 cycles, lyr_done[k] -> lyr_strt[k+1] 2 cycles; all outputs registered.
// Backpressure: img_rdy is only accepted in IDLE (source holds it); a hung stage parks the FSM in ERR until clr_err.
module cnn_frame_sched #(
  parameter int              NUM_LAYERS = 5,
  parameter int              TO_W       = 16,
  parameter logic [TO_W-1:0] TIMEOUT    = TO_W'(16'hFFFF)
) (
  input logic               clk,
  input logic               rst,
  cnn_frame_sched_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_TX      = 3'd3,
    S_TX_WAIT = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  localparam logic [2:0]      LP_LAST_STAGE = 3'(NUM_LAYERS - 1);
  localparam logic [2:0]      LP_TX_STAGE   = 3'(NUM_LAYERS);
  localparam logic [TO_W-1:0] LP_TO_LAST    = TIMEOUT - TO_W'(1);

  state_t                r_state;
  logic [2:0]            r_stage;
  logic [TO_W-1:0]       r_wd;
  logic                  r_img_ack;
  logic [NUM_LAYERS-1:0] r_lyr_strt;
  logic                  r_tx_trmt;
  logic                  r_busy;
  logic                  r_err;
  logic [2:0]            r_err_stage;
  logic [7:0]            r_frame_cnt;

  logic [NUM_LAYERS-1:0] w_stage_oh;
  logic                  w_done_cur;
  logic                  w_to_hit;
  logic [TO_W-1:0]       w_wd_inc;

  // Only the done bit of the active stage may advance the sequence.
  assign w_stage_oh = NUM_LAYERS'(1) << r_stage;
  assign w_done_cur = |(bus.lyr_done & w_stage_oh);
  assign w_to_hit   = (r_wd == LP_TO_LAST);
  // Saturating increment so the watchdog can never wrap back below the limit.
  assign w_wd_inc   = (r_wd == {TO_W{1'b1}}) ? r_wd : r_wd + TO_W'(1);

  // Sequencer: strobes default low every cycle so each fires for exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_stage     <= 3'd0;
      r_wd        <= '0;
      r_img_ack   <= 1'b0;
      r_lyr_strt  <= '0;
      r_tx_trmt   <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_err_stage <= 3'd0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_img_ack  <= 1'b0;
      r_lyr_strt <= '0;
      r_tx_trmt  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.img_rdy) begin
            r_img_ack <= 1'b1;
            r_stage   <= 3'd0;
            r_busy    <= 1'b1;
            r_state   <= S_START;
          end
        end
        S_START: begin
          r_lyr_strt <= w_stage_oh;
          r_wd       <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          // done beats a timeout landing in the same cycle
          if (w_done_cur) begin
            if (r_stage == LP_LAST_STAGE) begin
              r_stage <= LP_TX_STAGE;
              r_state <= S_TX;
            end else begin
              r_stage <= r_stage + 3'd1;
              r_state <= S_START;
            end
          end else if (w_to_hit) begin
            r_err       <= 1'b1;
            r_err_stage <= r_stage;
            r_busy      <= 1'b0;
            r_state     <= S_ERR;
          end else begin
            r_wd <= w_wd_inc;
          end
        end
        S_TX: begin
          r_tx_trmt <= 1'b1;
          r_wd      <= '0;
          r_state   <= S_TX_WAIT;
        end
        S_TX_WAIT: begin
          if (bus.tx_done) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
            r_stage     <= 3'd0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else if (w_to_hit) begin
            r_err       <= 1'b1;
            r_err_stage <= r_stage;
            r_busy      <= 1'b0;
            r_state     <= S_ERR;
          end else begin
            r_wd <= w_wd_inc;
          end
        end
        S_ERR: begin
          // everything except clr_err is ignored here; err_stage stays latched
          if (bus.clr_err) begin
            r_err   <= 1'b0;
            r_stage <= 3'd0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.img_ack   = r_img_ack;
  assign bus.lyr_strt  = r_lyr_strt;
  assign bus.tx_trmt   = r_tx_trmt;
  assign bus.busy      = r_busy;
  assign bus.cur_layer = r_stage;
  assign bus.err       = r_err;
  assign bus.err_stage = r_err_stage;
  assign bus.frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_cnn_frame_sched.sv
// Bench for cnn_frame_sched: one instance with the long default watchdog, one with TIMEOUT=16.
// Latency: n/a.
// Backpressure: n/a.
module tb_cnn_frame_sched;
  localparam int NL = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  cnn_frame_sched_if #(.NUM_LAYERS(NL)) if_n ();
  cnn_frame_sched_if #(.NUM_LAYERS(NL)) if_w ();

  cnn_frame_sched #(.NUM_LAYERS(NL), .TO_W(16), .TIMEOUT(16'hFFFF)) dut_n (
    .clk (clk),
    .rst (rst),
    .bus (if_n)
  );

  cnn_frame_sched #(.NUM_LAYERS(NL), .TO_W(16), .TIMEOUT(16'd16)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (if_w)
  );

  // Watchdog scenarios: stage whose answer is delayed (NL = the UART), that delay, and the outcome.
  typedef struct {
    string name;
    int    stage;
    int    dly;
    bit    exp_err;
    int    exp_es;
  } wrow_t;

  wrow_t rows[8];

  // results of the last run_n call
  int strt_at[NL];
  int strt_val[NL];
  int strt_cnt, tx_at, tx_cnt, ack_cnt, ack_at, rdy_at, end_at, cur_at_stray;
  int ovl = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs_n();
    return int'({if_n.img_ack, if_n.lyr_strt, if_n.tx_trmt, if_n.busy, if_n.cur_layer,
                 if_n.err, if_n.err_stage, if_n.frame_cnt});
  endfunction

  function automatic int outs_w();
    return int'({if_w.img_ack, if_w.lyr_strt, if_w.tx_trmt, if_w.busy, if_w.cur_layer,
                 if_w.err, if_w.err_stage, if_w.frame_cnt});
  endfunction

  // Drives one frame on dut_n acting as the layers and UART. Called and returns at a negedge.
  task automatic run_n(input int ldly, input int tdly, input bit hold, input bit stray, input int abort_stage);
    logic [7:0] fc0;
    int due_l, due_k, due_t, s2;
    bit fin;
    fc0 = if_n.frame_cnt;
    strt_cnt = 0; tx_cnt = 0; ack_cnt = 0; cur_at_stray = -1;
    due_l = -1; due_k = 0; due_t = -1; s2 = -1; fin = 1'b0;
    rdy_at = cyc;
    if_n.img_rdy = 1'b1;
    for (int i = 0; i < 2000 && !fin; i++) begin
      @(negedge clk);
      if (if_n.img_ack) begin
        ack_cnt++;
        ack_at = cyc;
        if (!hold) if_n.img_rdy = 1'b0;
      end
      if (if_n.tx_trmt && (if_n.lyr_strt != '0)) ovl++;
      for (int k = 0; k < NL; k++) begin
        if (if_n.lyr_strt[k]) begin
          strt_at[k]  = cyc;
          strt_val[k] = int'(if_n.lyr_strt);
          strt_cnt++;
          due_l = cyc + ldly;
          due_k = k;
          if (k == 2) s2 = cyc;
          if (k == abort_stage) fin = 1'b1;
        end
      end
      if (if_n.tx_trmt) begin
        tx_at = cyc;
        tx_cnt++;
        due_t = cyc + tdly;
      end
      if (stray && s2 >= 0 && cyc == s2 + 5) cur_at_stray = int'(if_n.cur_layer);
      if_n.lyr_done = '0;
      if (cyc == due_l) if_n.lyr_done[due_k] = 1'b1;
      if_n.tx_done = (cyc == due_t);
      if (stray && s2 >= 0) begin
        if (cyc == s2 + 1) if_n.lyr_done[0] = 1'b1;
        if (cyc == s2 + 2) if_n.lyr_done[NL-1] = 1'b1;
        if (cyc == s2 + 3) if_n.tx_done = 1'b1;
      end
      if (if_n.frame_cnt != fc0) begin
        fin = 1'b1;
        end_at = cyc;
      end
    end
    if (!fin) chk("frame_n_timeout", 0, 1);
  endtask

  // Timing of a layer-10 / UART-20 frame on dut_n.
  task automatic check_frame(input string tag);
    chk($sformatf("%s_ack_cnt", tag), ack_cnt, 1);
    chk($sformatf("%s_strt_cnt", tag), strt_cnt, NL);
    chk($sformatf("%s_tx_cnt", tag), tx_cnt, 1);
    for (int k = 0; k < NL; k++)
      chk($sformatf("%s_strt_val%0d", tag, k), strt_val[k], 1 << k);
    for (int k = 1; k < NL; k++)
      chk($sformatf("%s_strt_gap%0d", tag, k), strt_at[k] - strt_at[k-1], 12);
    chk($sformatf("%s_tx_gap", tag), tx_at - strt_at[NL-1], 12);
    chk($sformatf("%s_end_gap", tag), end_at - tx_at, 21);
    chk($sformatf("%s_busy_end", tag), int'(if_n.busy), 0);
  endtask

  // One watchdog scenario on dut_w.
  task automatic run_w(input wrow_t r);
    logic [7:0] fc0, dfc;
    int due_l, due_k, due_t, last_s, err_at, first_k, acks;
    bit fin;
    fc0 = if_w.frame_cnt;
    due_l = -1; due_k = 0; due_t = -1; last_s = -1; err_at = -1; first_k = -1; fin = 1'b0;
    if_w.img_rdy = 1'b1;
    for (int i = 0; i < 400 && !fin; i++) begin
      @(negedge clk);
      if (if_w.img_ack) if_w.img_rdy = 1'b0;
      for (int k = 0; k < NL; k++) begin
        if (if_w.lyr_strt[k]) begin
          if (first_k < 0) first_k = k;
          last_s = cyc;
          due_k  = k;
          due_l  = cyc + ((k == r.stage) ? r.dly : 3);
        end
      end
      if (if_w.tx_trmt) begin
        last_s = cyc;
        due_t  = cyc + ((r.stage == NL) ? r.dly : 3);
      end
      if_w.lyr_done = '0;
      if (cyc == due_l) if_w.lyr_done[due_k] = 1'b1;
      if_w.tx_done = (cyc == due_t);
      if (if_w.err) begin
        err_at = cyc;
        fin = 1'b1;
      end
      if (if_w.frame_cnt != fc0) fin = 1'b1;
    end
    if (!fin) chk($sformatf("%s_timeout", r.name), 0, 1);
    dfc = if_w.frame_cnt - fc0;
    chk($sformatf("%s_first_stage", r.name), first_k, 0);
    chk($sformatf("%s_err", r.name), int'(if_w.err), int'(r.exp_err));
    chk($sformatf("%s_frames", r.name), int'(dfc), r.exp_err ? 0 : 1);
    chk($sformatf("%s_busy", r.name), int'(if_w.busy), 0);
    if (r.exp_err) begin
      chk($sformatf("%s_err_stage", r.name), int'(if_w.err_stage), r.exp_es);
      chk($sformatf("%s_err_latency", r.name), err_at - last_s, 16);
      // ERR must ignore every done and a fresh image request
      acks = 0;
      if_w.lyr_done = '1;
      if_w.tx_done  = 1'b1;
      if_w.img_rdy  = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (if_w.img_ack) acks++;
      end
      if_w.lyr_done = '0;
      if_w.tx_done  = 1'b0;
      if_w.img_rdy  = 1'b0;
      chk($sformatf("%s_err_held", r.name), int'(if_w.err), 1);
      chk($sformatf("%s_no_ack_in_err", r.name), acks, 0);
      if_w.clr_err = 1'b1;
      @(negedge clk);
      if_w.clr_err = 1'b0;
      chk($sformatf("%s_err_cleared", r.name), int'(if_w.err), 0);
      chk($sformatf("%s_err_stage_hold", r.name), int'(if_w.err_stage), r.exp_es);
    end else begin
      if_w.tx_done = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int tot_ack, tot_strt, tot_tx, zeros;

    rows[0] = '{name: "plain",   stage: 0,  dly: 3,    exp_err: 1'b0, exp_es: 0};
    rows[1] = '{name: "tie_l2",  stage: 2,  dly: 15,   exp_err: 1'b0, exp_es: 0};
    rows[2] = '{name: "tie_tx",  stage: NL, dly: 15,   exp_err: 1'b0, exp_es: 0};
    rows[3] = '{name: "hang_l2", stage: 2,  dly: 1000, exp_err: 1'b1, exp_es: 2};
    rows[4] = '{name: "late_l0", stage: 0,  dly: 16,   exp_err: 1'b1, exp_es: 0};
    rows[5] = '{name: "late_tx", stage: NL, dly: 16,   exp_err: 1'b1, exp_es: NL};
    rows[6] = '{name: "tie_l4",  stage: 4,  dly: 15,   exp_err: 1'b0, exp_es: 0};
    rows[7] = '{name: "hang_l4", stage: 4,  dly: 1000, exp_err: 1'b1, exp_es: 4};

    if_n.img_rdy = 1'b0; if_n.lyr_done = '0; if_n.tx_done = 1'b0; if_n.clr_err = 1'b0;
    if_w.img_rdy = 1'b0; if_w.lyr_done = '0; if_w.tx_done = 1'b0; if_w.clr_err = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("reset_outs_n", outs_n(), 0);
    chk("reset_outs_w", outs_w(), 0);
    rst = 1'b0;
    @(negedge clk);

    // nominal frame
    run_n(10, 20, 1'b0, 1'b0, -1);
    chk("nom_ack_lat", ack_at - rdy_at, 1);
    chk("nom_strt0_lat", strt_at[0] - rdy_at, 2);
    check_frame("nom");
    chk("nom_frame_cnt", int'(if_n.frame_cnt), 1);

    // stray dones while stage 2 waits
    run_n(10, 20, 1'b0, 1'b1, -1);
    check_frame("stray");
    chk("stray_cur_layer", cur_at_stray, 2);
    chk("stray_frame_cnt", int'(if_n.frame_cnt), 2);

    // watchdog / tie table
    for (int i = 0; i < 8; i++) run_w(rows[i]);

    // async reset during WAIT of stage 3, asserted away from any clock edge
    run_n(10, 20, 1'b0, 1'b0, 3);
    chk("pre_reset_strt3", strt_val[3], 8);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_outs", outs_n(), 0);
    if_n.lyr_done = '0;
    if_n.tx_done  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_n(2, 2, 1'b0, 1'b0, -1);
    chk("post_reset_strt0_lat", strt_at[0] - rdy_at, 2);
    chk("post_reset_strt0_val", strt_val[0], 1);
    chk("post_reset_frame_cnt", int'(if_n.frame_cnt), 1);

    // 256 back-to-back frames with img_rdy held high
    tot_ack = 0; tot_strt = 0; tot_tx = 0; zeros = 0; ovl = 0;
    for (int f = 0; f < 256; f++) begin
      run_n(1, 1, 1'b1, 1'b0, -1);
      tot_ack  += ack_cnt;
      tot_strt += strt_cnt;
      tot_tx   += tx_cnt;
      if (if_n.frame_cnt == 8'd0) zeros++;
    end
    if_n.img_rdy = 1'b0;
    chk("b2b_acks", tot_ack, 256);
    chk("b2b_strts", tot_strt, 256 * NL);
    chk("b2b_txs", tot_tx, 256);
    chk("b2b_wrap_seen", zeros, 1);
    chk("b2b_final_cnt", int'(if_n.frame_cnt), 1);
    chk("b2b_overlap", ovl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
